// File: rtl/lsu.sv
// lsu - load/store unit between the ALU and data memory of the RV32I core.
//
// Loads (opcode 0000011) and stores (opcode 0100011) use ALUResult as the
// byte address and run one word-wide transaction over a req/gnt/rvalid
// handshake. The unit forms byte strobes and lane-shifted write data, and
// sign- or zero-extends load results. It holds the pipeline (stall) until
// the access completes, then pulses done for one cycle.
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip memory and finish with
//               done=misalign=1 for one cycle; load_data is left unchanged.
//   undefined : misalign is tied to 0 and the offending low address bits are
//               dropped (half uses lane & 2, word uses lane 0).
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   valid_in          instruction present in the stage
//   opcode_reg        instruction opcode
//   funct3_reg        access size / signedness
//   ALUResult         effective byte address
//   store_data        rs2 value for stores
//   stall             holds the upstream pipeline
//   done              one-cycle completion pulse
//   load_data         registered, extended load result
//   mem_req/mem_we    memory request / write enable
//   mem_addr          word-aligned memory address
//   mem_wdata         lane-shifted store data
//   mem_wstrb         byte-lane enables (zero for loads)
//   mem_gnt           request accepted this cycle
//   mem_rvalid        read data valid
//   mem_rdata         read word
//   misalign          misaligned-access flag (valid with done)

module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [6:0]        opcode_reg,
  input  logic [2:0]        funct3_reg,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              misalign
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int         AW_IN    = (ADDR_W < 32) ? ADDR_W : 32;

  // state | meaning
  // IDLE  | waiting for a load/store; captures the access
  // REQ   | mem_req high, outputs held until mem_gnt
  // WAIT  | load granted, waiting for mem_rvalid
  // DONE  | one-cycle done pulse, no capture
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic              is_store;
  logic              is_mem_op;
  logic              size_byte;
  logic              size_half;
  logic              start_trap;
  logic              capture;
  logic              take_rdata;
  logic [1:0]        lane_eff;
  logic [ADDR_W-1:0] addr_word;
  logic [31:0]       wdata_sized;
  logic [31:0]       wdata_new;
  logic [3:0]        wstrb_new;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        lane_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;

  logic [31:0]       rdata_shift;
  logic [31:0]       load_ext;

  // Decode of the incoming instruction, used only on the capture edge.
  always_comb begin
    is_store  = (opcode_reg == OP_STORE);
    is_mem_op = valid_in && ((opcode_reg == OP_LOAD) || is_store);
    size_byte = (funct3_reg[1:0] == 2'b00);
    size_half = (funct3_reg[1:0] == 2'b01);

    addr_word = '0;
    addr_word[AW_IN-1:0] = ALUResult[AW_IN-1:0];
    addr_word[1:0] = 2'b00;

    // Alignment-violating low bits are dropped for lane selection.
    if (size_byte) begin
      lane_eff = ALUResult[1:0];
    end else if (size_half) begin
      lane_eff = {ALUResult[1], 1'b0};
    end else begin
      lane_eff = 2'b00;
    end

    // Narrow values are replicated across the word before shifting, so the
    // addressed lanes always carry the value.
    if (size_byte) begin
      wdata_sized = {4{store_data[7:0]}};
      wstrb_new   = 4'b0001 << lane_eff;
    end else if (size_half) begin
      wdata_sized = {2{store_data[15:0]}};
      wstrb_new   = 4'b0011 << lane_eff;
    end else begin
      wdata_sized = store_data;
      wstrb_new   = 4'b1111;
    end
    wdata_new = wdata_sized << {lane_eff, 3'b000};

`ifdef LSU_MISALIGN_TRAP_EN
    start_trap = (size_half && ALUResult[0]) ||
                 (!size_byte && !size_half && (ALUResult[1:0] != 2'b00));
`else
    start_trap = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    capture    = 1'b0;
    take_rdata = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem_op) begin
          stall      = 1'b1;
          capture    = 1'b1;
          state_next = start_trap ? DONE : REQ;
        end
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_next = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          take_rdata = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory-side outputs come from the captured access and are only
  // non-zero while the request is outstanding.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (state == REQ) begin
      mem_we   = we_q;
      mem_addr = addr_q;
      if (we_q) begin
        mem_wdata = wdata_q;
        mem_wstrb = wstrb_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      lane_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (capture) begin
      addr_q   <= addr_word;
      lane_q   <= lane_eff;
      funct3_q <= funct3_reg;
      we_q     <= is_store;
      wdata_q  <= wdata_new;
      wstrb_q  <= wstrb_new;
    end
  end

  always_comb begin
    rdata_shift = mem_rdata >> {lane_q, 3'b000};
    case (funct3_q[1:0])
      2'b00: load_ext = funct3_q[2] ? {24'h000000, rdata_shift[7:0]}
                                    : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01: load_ext = funct3_q[2] ? {16'h0000, rdata_shift[15:0]}
                                    : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_data <= '0;
    end else if (take_rdata) begin
      load_data <= load_ext;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else if (capture) begin
      trap_q <= start_trap;
    end
  end

  assign misalign = (state == DONE) && trap_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [6:0]  opcode_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] ALUResult;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        misalign;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_ld = 32'h0;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .opcode_reg (opcode_reg),
    .funct3_reg (funct3_reg),
    .ALUResult  (ALUResult),
    .store_data (store_data),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One load or store, cycle-by-cycle, against a byte-level model:
  // gd = extra cycles before grant, rd = cycles from grant to rvalid (>=1).
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input int gd, input int rd);
    int          size, lane, eff;
    bit          mis, trap;
    logic [3:0]  exp_strb;
    logic [7:0]  wbyte [4];
    logic [31:0] exp_addr;
    longint      v;
    logic [31:0] exp_ld;

    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    lane = int'(addr % 4);
    mis  = (lane % size) != 0;
    trap = TRAP_EN && mis;
    eff  = lane - (lane % size);
    exp_addr = addr - (addr % 4);
    exp_strb = 4'b0000;
    for (int i = 0; i < 4; i++) wbyte[i] = 8'h00;
    for (int i = 0; i < size; i++) begin
      exp_strb[eff + i] = 1'b1;
      wbyte[eff + i] = sdata[8*i +: 8];
    end
    v = 0;
    for (int i = 0; i < size; i++) v += longint'((rdata >> (8 * (eff + i))) & 32'hFF) << (8 * i);
    if (size < 4 && f3[2] == 1'b0 && v >= (longint'(1) << (8 * size - 1)))
      v -= longint'(1) << (8 * size);
    exp_ld = v[31:0];

    next_cycle();
    valid_in   = 1'b1;
    opcode_reg = st ? OP_STORE : OP_LOAD;
    funct3_reg = f3;
    ALUResult  = addr;
    store_data = sdata;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("cap_stall", {31'b0, stall}, 32'd1);
    chk("cap_req", {31'b0, mem_req}, 32'd0);
    chk("cap_done", {31'b0, done}, 32'd0);

    if (trap) begin
      next_cycle();
      valid_in = 1'b0;
      ALUResult = $urandom;
      @(negedge clk);
      chk("trap_done", {31'b0, done}, 32'd1);
      chk("trap_misalign", {31'b0, misalign}, 32'd1);
      chk("trap_req", {31'b0, mem_req}, 32'd0);
      chk("trap_ld_hold", load_data, last_ld);
    end else begin
      for (int k = 0; k <= gd; k++) begin
        next_cycle();
        valid_in   = 1'b0;
        opcode_reg = 7'($urandom);
        funct3_reg = 3'($urandom);
        ALUResult  = $urandom;
        store_data = $urandom;
        mem_gnt    = (k == gd);
        @(negedge clk);
        chk("req_req", {31'b0, mem_req}, 32'd1);
        chk("req_addr", mem_addr, exp_addr);
        chk("req_we", {31'b0, mem_we}, {31'b0, st});
        chk("req_wstrb", {28'b0, mem_wstrb}, st ? {28'b0, exp_strb} : 32'd0);
        chk("req_stall", {31'b0, stall}, 32'd1);
        chk("req_misalign", {31'b0, misalign}, 32'd0);
        if (st)
          for (int i = 0; i < 4; i++)
            if (exp_strb[i]) chk("req_wbyte", {24'b0, mem_wdata[8*i +: 8]}, {24'b0, wbyte[i]});
      end
      if (!st) begin
        for (int k = 1; k <= rd; k++) begin
          next_cycle();
          mem_gnt    = 1'b0;
          mem_rvalid = (k == rd);
          mem_rdata  = (k == rd) ? rdata : $urandom;
          @(negedge clk);
          chk("wait_req", {31'b0, mem_req}, 32'd0);
          chk("wait_stall", {31'b0, stall}, 32'd1);
          chk("wait_done", {31'b0, done}, 32'd0);
        end
      end
      // A new access presented during DONE must not be captured.
      next_cycle();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      valid_in   = 1'b1;
      opcode_reg = OP_STORE;
      @(negedge clk);
      chk("done_done", {31'b0, done}, 32'd1);
      chk("done_stall", {31'b0, stall}, 32'd0);
      chk("done_req", {31'b0, mem_req}, 32'd0);
      chk("done_misalign", {31'b0, misalign}, 32'd0);
      if (!st) last_ld = exp_ld;
      chk("done_load_data", load_data, last_ld);
    end
  endtask

  task automatic non_mem(input logic [6:0] opc);
    next_cycle();
    valid_in   = 1'b1;
    opcode_reg = opc;
    funct3_reg = 3'($urandom);
    ALUResult  = $urandom;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("nm_stall", {31'b0, stall}, 32'd0);
    chk("nm_req", {31'b0, mem_req}, 32'd0);
    chk("nm_done", {31'b0, done}, 32'd0);
    next_cycle();
    valid_in = 1'b0;
    @(negedge clk);
    chk("nm_req2", {31'b0, mem_req}, 32'd0);
    chk("nm_done2", {31'b0, done}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    valid_in   = 1'b0;
    opcode_reg = 7'h0;
    funct3_reg = 3'h0;
    ALUResult  = 32'h0;
    store_data = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;

    // Reset state
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    next_cycle();
    rst = 1'b0;

    // Directed cases
    access(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 1);   // SW
    chk("sw_wdata_check_done", {31'b0, done}, 32'd1);
    access(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 1);   // SB
    access(1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h0080_0000, 0, 1);   // LB
    chk("lb_value", load_data, 32'hFFFF_FF80);
    access(1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h0080_0000, 0, 1);   // LBU
    chk("lbu_value", load_data, 32'h0000_0080);
    access(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_7F00, 2, 3);   // LH delayed
    chk("lh_value", load_data, 32'hFFFF_8001);
    access(1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h1234_5678, 0, 1);   // LW misaligned
    if (!TRAP_EN) chk("lw_mis_value", load_data, 32'h1234_5678);
    non_mem(7'b0110011);                                               // ADD

    // Reset during WAIT, late rvalid afterwards
    next_cycle();
    valid_in   = 1'b1;
    opcode_reg = OP_LOAD;
    funct3_reg = 3'b010;
    ALUResult  = 32'h0000_0040;
    next_cycle();
    valid_in = 1'b0;
    mem_gnt  = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    chk("rw_wait_stall", {31'b0, stall}, 32'd1);
    next_cycle();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rw_req", {31'b0, mem_req}, 32'd0);
    chk("rw_stall", {31'b0, stall}, 32'd0);
    chk("rw_done", {31'b0, done}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("rw_done_late", {31'b0, done}, 32'd0);
      chk("rw_load_data", load_data, 32'd0);
    end
    last_ld = 32'h0;

    // Randomized accesses
    for (int n = 0; n < 80; n++) begin
      bit st;
      logic [2:0] f3;
      st = 1'($urandom_range(0, 1));
      if (st) begin
        case ($urandom_range(0, 3))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          default: f3 = 3'b011;
        endcase
      end else begin
        case ($urandom_range(0, 5))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          4: f3 = 3'b101;
          default: f3 = 3'b110;
        endcase
      end
      access(st, f3, $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) begin
        logic [6:0] opc;
        opc = 7'($urandom);
        if (opc == OP_LOAD || opc == OP_STORE) opc = 7'b0010011;
        non_mem(opc);
      end
    end

    next_cycle();
    valid_in = 1'b0;
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
